// File: rtl/obstacle_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_scheduler
//   Owns a pool of NUM_SLOTS obstacle instances. Once per frame (update strobe)
//   it decides whether a new obstacle starts, which slot it goes into and which
//   type it is. Type comes from rng_data with a speed gate on pterodactyls and
//   a limit on consecutive duplicates.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   update            frame strobe; all state advances only when high
//   speed             horizon speed, x1024
//   rng_data          random word, bits [1:0] select the type
//   game_start        game begins (sampled on update)
//   crash             game over (sampled on update)
//   slot_remove       per-slot remove flag from the obstacle
//   slot_x_pos        per-slot signed x position, px
//   slot_width        per-slot width, px
//   slot_gap          per-slot required trailing gap, px
//   slot_start        one-frame start request to the obstacle
//   slot_typ          type for each slot, valid while slot_start is high
//   slot_busy         slot is owned by a live obstacle
//
// Type encoding: 0 NONE, 1 CACTUS_SMALL, 2 CACTUS_LARGE, 3 PTERODACTYL.
// -----------------------------------------------------------------------------
module obstacle_scheduler #(
   parameter int NUM_SLOTS       = 3,
   parameter int GAME_WIDTH      = 600,
   parameter int CLEAR_FRAMES    = 60,
   parameter int PTERO_MIN_SPEED = 8704,
   parameter int MAX_DUP         = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        update,
   input  logic [14:0]                 speed,
   input  logic [10:0]                 rng_data,
   input  logic                        game_start,
   input  logic                        crash,
   input  logic [NUM_SLOTS-1:0]        slot_remove,
   input  logic [NUM_SLOTS-1:0][10:0]  slot_x_pos,
   input  logic [NUM_SLOTS-1:0][9:0]   slot_width,
   input  logic [NUM_SLOTS-1:0][10:0]  slot_gap,
   output logic [NUM_SLOTS-1:0]        slot_start,
   output logic [NUM_SLOTS-1:0][2:0]   slot_typ,
   output logic [NUM_SLOTS-1:0]        slot_busy
);

   localparam int LAST_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int CNT_W  = $clog2(CLEAR_FRAMES + 1);
   localparam logic signed [12:0] GW_S = 13'(GAME_WIDTH);

   typedef enum logic [1:0] {IDLE, CLEARING, RUN, CRASHED} state_t;
   typedef enum logic [2:0] {
      T_NONE  = 3'd0,
      T_SMALL = 3'd1,
      T_LARGE = 3'd2,
      T_PTERO = 3'd3
   } type_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    clr_cnt;
   logic [LAST_W-1:0]   last;
   type_t               hist [MAX_DUP];   // hist[0] is the most recent spawn

   logic                clr_last, run_en, pending, have_free, gap_clear, spawn, dup;
   logic [LAST_W-1:0]   free_idx;
   logic [NUM_SLOTS-1:0] spawn_vec, free_vec;
   logic signed [12:0]  x_ext, w_ext, g_ext, tail;
   type_t               cand, pick;
   logic                unused_rng;

   assign unused_rng = ^rng_data[10:2];

   function automatic type_t rng_type(input logic [1:0] r);
      case (r)
         2'd2:    return T_LARGE;
         2'd3:    return T_PTERO;
         default: return T_SMALL;
      endcase
   endfunction

   function automatic type_t gate_ptero(input type_t t, input logic [14:0] spd);
      if (t == T_PTERO && spd < 15'(PTERO_MIN_SPEED))
         return T_SMALL;
      return t;
   endfunction

   function automatic type_t rotate(input type_t t);
      case (t)
         T_SMALL: return T_LARGE;
         T_LARGE: return T_PTERO;
         default: return T_SMALL;
      endcase
   endfunction

   // ---------------- FSM next state ----------------
   assign clr_last = (clr_cnt == CNT_W'(CLEAR_FRAMES - 1));

   always_comb begin
      state_d = state_q;
      if (update) begin
         case (state_q)
            IDLE:     if (game_start && !crash) state_d = CLEARING;
            CLEARING: if (crash) state_d = CRASHED;
                      else if (clr_last) state_d = RUN;
            RUN:      if (crash) state_d = CRASHED;
            default:  state_d = CRASHED;
         endcase
      end
   end

   // ---------------- spawn decision ----------------
   // The last clearing update already counts as running, so the first start
   // is registered on the CLEAR_FRAMES-th update after game_start.
   assign run_en  = update && !crash &&
                    (state_q == RUN || (state_q == CLEARING && clr_last));
   assign pending = |slot_start;

   always_comb begin
      free_idx  = '0;
      have_free = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!slot_busy[i]) begin
            free_idx  = LAST_W'(i);
            have_free = 1'b1;
         end
      end
   end

   // Trailing edge of the most recent obstacle; x may be negative once the
   // obstacle is partly off the left edge.
   always_comb begin
      x_ext     = {{2{slot_x_pos[last][10]}}, slot_x_pos[last]};
      w_ext     = {3'b000, slot_width[last]};
      g_ext     = {2'b00, slot_gap[last]};
      tail      = x_ext + w_ext + g_ext;
      gap_clear = (tail < GW_S);
   end

   assign spawn = run_en && !pending && have_free &&
                  (!(|slot_busy) || !slot_busy[last] || gap_clear);
   assign spawn_vec = spawn ? (NUM_SLOTS'(1) << free_idx) : '0;
   // A remove seen while a start is pending belongs to the slot's previous life.
   assign free_vec  = slot_remove & ~slot_start;

   // ---------------- type pick ----------------
   always_comb begin
      cand = gate_ptero(rng_type(rng_data[1:0]), speed);
      dup  = 1'b1;
      for (int i = 0; i < MAX_DUP; i++) begin
         if (hist[i] != cand) dup = 1'b0;
      end
      pick = dup ? gate_ptero(rotate(cand), speed) : cand;
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt    <= '0;
         last       <= '0;
         slot_start <= '0;
         slot_busy  <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) slot_typ[i] <= T_NONE;
         for (int i = 0; i < MAX_DUP; i++)   hist[i]     <= T_NONE;
      end else if (update) begin
         // spawn_vec is zero whenever a start is pending or a crash is seen,
         // so this both raises and retires the one-frame start pulse.
         slot_start <= spawn_vec;
         if (state_q == CLEARING && !clr_last) clr_cnt <= clr_cnt + CNT_W'(1);
         if (state_d != CRASHED) slot_busy <= (slot_busy & ~free_vec) | spawn_vec;
         if (spawn) begin
            slot_typ[free_idx] <= pick;
            last               <= free_idx;
            hist[0]            <= pick;
            for (int i = 1; i < MAX_DUP; i++) hist[i] <= hist[i-1];
         end
      end
   end

endmodule
